bitwise_gen: RTL and testbench

BITWISE_GEN -- requirements
Module: bitwise_gen

---
 rtl/bitwise_pkg.sv | 30 +++
 rtl/bitwise_alu.sv | 35 +++
 rtl/bitwise_gen.sv | 139 +++++++++++++
 tb/tb_bitwise_gen.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/bitwise_pkg.sv
// Shared opcode and state encodings for the bitwise_gen datapath.
//   op_e    : 3-bit opcode (000-011 keep their legacy meanings)
//   state_e : sequencer states
//   writes_rn() : true for ops whose EXEC writeback targets Rn instead of R0
package bitwise_pkg;

   typedef enum logic [2:0] {
      OP_MOV = 3'b000,
      OP_XOR = 3'b001,
      OP_ASL = 3'b010,
      OP_SWP = 3'b011,
      OP_AND = 3'b100,
      OP_OR  = 3'b101,
      OP_ASR = 3'b110,
      OP_ROL = 3'b111
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_EXEC  = 3'd2,
      ST_SWAP2 = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   function automatic logic writes_rn(op_e op);
      return (op == OP_MOV) || (op == OP_SWP);
   endfunction

endpackage

// File: rtl/bitwise_alu.sv
// Combinational op-to-result function.
//   op_i   : opcode
//   acc_i  : accumulator R0
//   opnd_i : operand register value captured in tmp
//   imm_i  : immediate from the instruction register
//   res_o  : value written back during EXEC (to R0, or to Rn for MOV/SWP)
module bitwise_alu
   import bitwise_pkg::*;
#(
   parameter int unsigned W = 8
) (
   input  op_e            op_i,
   input  logic [W-1:0]   acc_i,
   input  logic [W-1:0]   opnd_i,
   input  logic [W-1:0]   imm_i,
   output logic [W-1:0]   res_o
);

   always_comb begin
      res_o = acc_i;
      case (op_i)
         OP_MOV:  res_o = imm_i;
         OP_XOR:  res_o = acc_i ^ opnd_i;
         OP_ASL:  res_o = {acc_i[W-2:0], 1'b0};
         // SWP first half: Rn receives the old R0
         OP_SWP:  res_o = acc_i;
         OP_AND:  res_o = acc_i & opnd_i;
         OP_OR:   res_o = acc_i | opnd_i;
         OP_ASR:  res_o = {acc_i[W-1], acc_i[W-1:1]};
         OP_ROL:  res_o = {acc_i[W-2:0], acc_i[W-1]};
         default: res_o = acc_i;
      endcase
   end

endmodule

// File: rtl/bitwise_gen.sv
// Multi-cycle bitwise instruction engine with an NREG x W register file.
//   clk, reset_n : clock, asynchronous active-low reset
//   s            : start, sampled only in IDLE
//   op, rn, in   : opcode, register index, MOV immediate (latched on start)
//   out          : always R0
//   done         : one-cycle completion pulse
//   busy         : high whenever the sequencer is not IDLE
module bitwise_gen
   import bitwise_pkg::*;
#(
   parameter int unsigned W    = 8,
   parameter int unsigned NREG = 4
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    s,
   input  logic [2:0]              op,
   input  logic [$clog2(NREG)-1:0] rn,
   input  logic [W-1:0]            in,
   output logic [W-1:0]            out,
   output logic                    done,
   output logic                    busy
);

   localparam int unsigned RW = $clog2(NREG);

   // sequencer, operand and instruction registers
   state_e         state_q, state_d;
   logic [W-1:0]   tmp_q, tmp_d;
   op_e            ir_op_q, ir_op_d;
   logic [RW-1:0]  ir_rn_q, ir_rn_d;
   logic [W-1:0]   ir_imm_q, ir_imm_d;
   logic           done_q, done_d;
   logic           busy_q, busy_d;
   logic [W-1:0]   r_q [NREG];

   // single register-file write port
   logic           wr_en;
   logic [RW-1:0]  wr_idx;
   logic [W-1:0]   wr_data;

   // observable names for benches
   logic [W-1:0]   R [NREG];
   logic [W-1:0]   tmp;
   logic [W-1:0]   alu_out;
   state_e         state;

   assign R     = r_q;
   assign tmp   = tmp_q;
   assign state = state_q;

   assign out  = R[0];
   assign done = done_q;
   assign busy = busy_q;

   bitwise_alu #(.W(W)) u_alu (
      .op_i   (ir_op_q),
      .acc_i  (R[0]),
      .opnd_i (tmp),
      .imm_i  (ir_imm_q),
      .res_o  (alu_out)
   );

   // next-state, operand capture and writeback selection
   always_comb begin
      state_d  = state;
      tmp_d    = tmp;
      ir_op_d  = ir_op_q;
      ir_rn_d  = ir_rn_q;
      ir_imm_d = ir_imm_q;
      wr_en    = 1'b0;
      wr_idx   = '0;
      wr_data  = '0;

      case (state)
         ST_IDLE: begin
            if (s) begin
               ir_op_d  = op_e'(op);
               ir_rn_d  = rn;
               ir_imm_d = in;
               state_d  = ST_LOAD;
            end
         end
         ST_LOAD: begin
            tmp_d   = R[ir_rn_q];
            state_d = ST_EXEC;
         end
         ST_EXEC: begin
            wr_en   = 1'b1;
            wr_data = alu_out;
            wr_idx  = writes_rn(ir_op_q) ? ir_rn_q : RW'(0);
            state_d = (ir_op_q == OP_SWP) ? ST_SWAP2 : ST_DONE;
         end
         ST_SWAP2: begin
            // SWP second half: R0 receives the old Rn
            wr_en   = 1'b1;
            wr_idx  = '0;
            wr_data = tmp;
            state_d = ST_DONE;
         end
         ST_DONE: state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase

      done_d = (state_d == ST_DONE);
      busy_d = (state_d != ST_IDLE);
   end

   // sequencer and instruction state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= ST_IDLE;
         tmp_q    <= '0;
         ir_op_q  <= OP_MOV;
         ir_rn_q  <= '0;
         ir_imm_q <= '0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         tmp_q    <= tmp_d;
         ir_op_q  <= ir_op_d;
         ir_rn_q  <= ir_rn_d;
         ir_imm_q <= ir_imm_d;
         done_q   <= done_d;
         busy_q   <= busy_d;
      end
   end

   // register file
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int unsigned i = 0; i < NREG; i++) r_q[i] <= '0;
      end else if (wr_en) begin
         r_q[wr_idx] <= wr_data;
      end
   end

endmodule

// File: tb/tb_bitwise_gen.sv
// Self-checking bench for bitwise_gen: directed cases plus randomized
// instruction streams on a W=8/NREG=4 and a W=16/NREG=8 instance.
module tb_bitwise_gen;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic reset_n;

   logic        s8;
   logic [2:0]  op8;
   logic [1:0]  rn8;
   logic [7:0]  in8;
   logic [7:0]  out8;
   logic        done8, busy8;

   logic        s16;
   logic [2:0]  op16;
   logic [2:0]  rn16;
   logic [15:0] in16;
   logic [15:0] out16;
   logic        done16, busy16;

   int n_checks = 0;
   int n_fail   = 0;
   int m [2][8];   // reference register files: [0] small build, [1] wide build

   bitwise_gen #(.W(8), .NREG(4)) dut8 (
      .clk(clk), .reset_n(reset_n), .s(s8), .op(op8), .rn(rn8), .in(in8),
      .out(out8), .done(done8), .busy(busy8)
   );

   bitwise_gen #(.W(16), .NREG(8)) dut16 (
      .clk(clk), .reset_n(reset_n), .s(s16), .op(op16), .rn(rn16), .in(in16),
      .out(out16), .done(done16), .busy(busy16)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [31:0] get_reg(input int b, input int i);
      if (b == 1) return 32'(dut16.R[3'(i)]);
      return 32'(dut8.R[2'(i)]);
   endfunction

   function automatic logic get_done(input int b);
      return (b == 1) ? done16 : done8;
   endfunction

   function automatic logic get_busy(input int b);
      return (b == 1) ? busy16 : busy8;
   endfunction

   function automatic logic [31:0] get_out(input int b);
      return (b == 1) ? 32'(out16) : 32'(out8);
   endfunction

   task automatic drive(input int b, input logic sv, input int o, input int r, input int imm);
      if (b == 1) begin
         s16 = sv; op16 = 3'(o); rn16 = 3'(r); in16 = 16'(imm);
      end else begin
         s8 = sv; op8 = 3'(o); rn8 = 2'(r); in8 = 8'(imm);
      end
   endtask

   // Architectural effect of one instruction, by plain arithmetic
   function automatic void model(input int b, input int o, input int r, input int imm);
      int w    = (b == 1) ? 16 : 8;
      int mask = (1 << w) - 1;
      int r0   = m[b][0];
      int t;
      case (o)
         0: m[b][r] = imm & mask;
         1: m[b][0] = r0 ^ m[b][r];
         2: m[b][0] = (r0 * 2) & mask;
         3: begin t = m[b][r]; m[b][r] = r0; m[b][0] = t; end
         4: m[b][0] = r0 & m[b][r];
         5: m[b][0] = r0 | m[b][r];
         6: m[b][0] = (r0 >> 1) | (r0 & (1 << (w - 1)));
         default: m[b][0] = ((r0 << 1) | (r0 >> (w - 1))) & mask;
      endcase
   endfunction

   function automatic void model_reset();
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < 8; i++) m[b][i] = 0;
   endfunction

   task automatic check_regs(input int b, input string tag);
      int n = (b == 1) ? 8 : 4;
      for (int i = 0; i < n; i++) check($sformatf("%s_r%0d", tag, i), get_reg(b, i), 32'(m[b][i]));
      check({tag, "_out"}, get_out(b), 32'(m[b][0]));
   endtask

   // noise: 0 = inputs scrambled with s low, 1 = random s pulses, 2 = MOV R3,99 held while busy
   task automatic run_instr(input int b, input int o, input int r, input int imm, input int noise);
      int edges;
      @(negedge clk);
      drive(b, 1'b1, o, r, imm);
      @(posedge clk); #1;
      edges = 1;
      check("busy_start", 32'(get_busy(b)), 32'd1);
      while (!get_done(b) && edges < 12) begin
         case (noise)
            1: drive(b, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom, $urandom);
            2: drive(b, 1'b1, 0, 3, 99);
            default: drive(b, 1'b0, $urandom_range(0, 7), $urandom, $urandom);
         endcase
         @(posedge clk); #1;
         edges++;
      end
      drive(b, 1'b0, 0, 0, 0);
      check($sformatf("latency_op%0d", o), 32'(edges), (o == 3) ? 32'd4 : 32'd3);
      model(b, o, r, imm);
      check_regs(b, $sformatf("op%0d", o));
      @(posedge clk); #1;
      check("done_pulse", 32'(get_done(b)), 32'd0);
      check("busy_end", 32'(get_busy(b)), 32'd0);
   endtask

   initial begin
      reset_n = 1'b0;
      drive(0, 1'b0, 0, 0, 0);
      drive(1, 1'b0, 0, 0, 0);
      model_reset();
      #1;
      check("rst_done", 32'(done8), 32'd0);
      check("rst_busy", 32'(busy8), 32'd0);
      check_regs(0, "rst");
      check_regs(1, "rst16");
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      // register load and XOR
      run_instr(0, 0, 1, 42, 0);
      run_instr(0, 0, 0, 11, 0);
      run_instr(0, 1, 1, 0, 0);
      check("xor_r0", get_out(0), 32'd33);
      check("xor_r1", get_reg(0, 1), 32'd42);

      // shifts and rotate
      run_instr(0, 0, 0, 'h81, 0);
      run_instr(0, 2, 0, 0, 0);
      check("asl", get_out(0), 32'h02);
      run_instr(0, 0, 0, 'h81, 0);
      run_instr(0, 7, 0, 0, 0);
      check("rol", get_out(0), 32'h03);
      run_instr(0, 0, 0, 'h81, 0);
      run_instr(0, 6, 0, 0, 0);
      check("asr", get_out(0), 32'hC0);

      // swap, including the self-swap
      run_instr(0, 0, 0, 33, 0);
      run_instr(0, 0, 2, 7, 0);
      run_instr(0, 3, 2, 0, 0);
      check("swp_r0", get_out(0), 32'd7);
      check("swp_r2", get_reg(0, 2), 32'd33);
      run_instr(0, 3, 0, 0, 0);
      check("swp_self", get_out(0), 32'd7);

      // self-operand XOR/AND/OR
      run_instr(0, 5, 0, 0, 0);
      run_instr(0, 4, 0, 0, 0);
      check("and_self", get_out(0), 32'd7);
      run_instr(0, 1, 0, 0, 0);
      check("xor_self", get_out(0), 32'd0);

      // start requests while busy are dropped
      run_instr(0, 0, 1, 200, 2);
      check("busy_ignore_r3", get_reg(0, 3), 32'd0);

      // reset during SWAP2
      run_instr(0, 0, 0, 33, 0);
      run_instr(0, 0, 2, 7, 0);
      @(negedge clk);
      drive(0, 1'b1, 3, 2, 0);
      @(posedge clk); #1;
      drive(0, 1'b0, 0, 0, 0);
      repeat (2) begin @(posedge clk); #1; end
      check("in_swap2", 32'(dut8.state), 32'(bitwise_pkg::ST_SWAP2));
      reset_n = 1'b0;
      #1;
      model_reset();
      check("midrst_busy", 32'(busy8), 32'd0);
      check("midrst_done", 32'(done8), 32'd0);
      check_regs(0, "midrst");
      @(negedge clk);
      reset_n = 1'b1;
      run_instr(0, 0, 1, 5, 0);
      check("post_rst_r1", get_reg(0, 1), 32'd5);

      // wide build
      run_instr(1, 0, 7, 'h8001, 0);
      run_instr(1, 3, 7, 0, 0);
      run_instr(1, 7, 0, 0, 0);
      check("wide_r0", get_out(1), 32'h0003);
      check("wide_r7", get_reg(1, 7), 32'd0);

      // randomized streams
      for (int k = 0; k < 60; k++)
         run_instr(0, $urandom_range(0, 7), $urandom_range(0, 3), $urandom, 1);
      for (int k = 0; k < 30; k++)
         run_instr(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
